// File: rtl/counter_pkg.sv
// Shared definitions for the truncated up/down counter and its command sequencer.
package counter_pkg;

    localparam int CTR_WIDTH = 4;
    localparam int CTR_MAX   = 10;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_UP   = 2'd1;
    localparam logic [1:0] OP_DOWN = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/counter_sequencer.sv
// Command-driven controller for the truncated up/down counter: LOAD / RUN_UP / RUN_DOWN
// with abort, a one-cycle done pulse carrying the resulting count, and idle hold.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH     = CTR_WIDTH,
    parameter int MAX_COUNT = CTR_MAX
) (
    input  logic             clock,
    input  logic             resetn,
    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             ctr_load,
    output logic [WIDTH-1:0] ctr_din,
    output logic             ctr_up_down,
    input  logic [WIDTH-1:0] ctr_count,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cmd_err,
    output logic             busy,
    output seq_state_t       dbg_state
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] next_count;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        load_val_d  = load_val_q;
        err_d       = 1'b0;
        cmd_ready   = 1'b0;
        ctr_load    = 1'b1;
        ctr_din     = ctr_count;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            if (cmd_data <= MAX_W) begin
                                load_val_d = cmd_data;
                                state_d    = S_LOAD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_UP, OP_DOWN: begin
                            if (cmd_data == '0) begin
                                state_d = S_DONE;
                            end else begin
                                dir_d       = (cmd_op == OP_DOWN);
                                remaining_d = cmd_data;
                                state_d     = S_RUN;
                            end
                        end
                        OP_RSVD: err_d = 1'b1;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                ctr_din = load_val_q;
                state_d = S_DONE;
            end
            S_RUN: begin
                // An abort cycle is a hold cycle; steps already taken stand.
                if (abort) begin
                    remaining_d = '0;
                    state_d     = S_DONE;
                end else begin
                    ctr_load    = 1'b0;
                    remaining_d = remaining_q - ONE_W;
                    if (remaining_q == ONE_W) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Value the counter will hold after this edge, so result can be registered
    // and still equal ctr_count during the DONE cycle.
    always_comb begin
        if (ctr_load) begin
            next_count = ctr_din;
        end else if (dir_q) begin
            next_count = (ctr_count == '0) ? MAX_W : ctr_count - ONE_W;
        end else begin
            next_count = (ctr_count >= MAX_W) ? '0 : ctr_count + ONE_W;
        end
    end

    assign done_d   = (state_d == S_DONE);
    assign result_d = (state_d == S_DONE) ? next_count : result_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            load_val_q  <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            load_val_q  <= load_val_d;
            done_q      <= done_d;
            result_q    <= result_d;
            err_q       <= err_d;
        end
    end

    assign ctr_up_down = dir_q;
    assign done        = done_q;
    assign result      = result_q;
    assign cmd_err     = err_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;

endmodule
